// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit for the E stage.
// Owns HI/LO and exposes a start/busy handshake for D-stage stalls.
module mdu_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        start_busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] out
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] hin_q, hin_d;
  logic [31:0] lon_q, lon_d;
  logic        dz_q, dz_d;

  logic        is_md, is_mul, is_div;
  logic [63:0] sprod, uprod;
  logic [31:0] bu, uq, ur;
  logic [31:0] a_mag, b_mag, bs, mq, mr, sq, sr;

  assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div = (op == OP_DIV) || (op == OP_DIVU);
  assign is_md  = is_mul || is_div;

  assign start_busy = start & is_md;
  assign busy       = (state_q == RUN);
  assign hi         = hi_q;
  assign lo         = lo_q;

  assign out = (op == OP_MFHI) ? hi_q :
               (op == OP_MFLO) ? lo_q : 32'd0;

  assign sprod = $signed({{32{A[31]}}, A}) *
                 $signed({{32{B[31]}}, B});
  assign uprod = {32'd0, A} * {32'd0, B};

  // Divisors forced nonzero; the dz flag suppresses writeback instead
  assign bu = (B == 32'd0) ? 32'd1 : B;
  assign uq = A / bu;
  assign ur = A % bu;

  // Signed divide on magnitudes: INT_MIN/-1 wraps to 0x80000000 rem 0
  assign a_mag = A[31] ? (~A + 32'd1) : A;
  assign b_mag = B[31] ? (~B + 32'd1) : B;
  assign bs    = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign mq    = a_mag / bs;
  assign mr    = a_mag % bs;
  assign sq    = (A[31] ^ B[31]) ? (~mq + 32'd1) : mq;
  assign sr    = A[31] ? (~mr + 32'd1) : mr;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    hin_d   = hin_q;
    lon_d   = lon_q;
    dz_d    = dz_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT:  {hin_d, lon_d} = sprod;
            OP_MULTU: {hin_d, lon_d} = uprod;
            OP_DIV: begin
              hin_d = sr;
              lon_d = sq;
            end
            OP_DIVU: begin
              hin_d = ur;
              lon_d = uq;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
          if (is_md) begin
            state_d = RUN;
            cnt_d   = is_mul ? 32'(MUL_CYCLES)
                             : 32'(DIV_CYCLES);
            dz_d    = is_div && (B == 32'd0);
          end
        end
      end
      RUN: begin
        if (cnt_q == 32'd1) begin
          state_d = IDLE;
          cnt_d   = 32'd0;
          if (!dz_q) begin
            hi_d = hin_q;
            lo_d = lon_q;
          end
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      hin_q   <= 32'd0;
      lon_q   <= 32'd0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hin_q   <= hin_d;
      lon_q   <= lon_d;
      dz_q    <= dz_d;
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed cases plus
// randomized ops against an arithmetic HI/LO reference model.
module tb_mdu_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] A, B;
  logic        busy, start_busy;
  logic [31:0] hi, lo, out;

  int tests = 0;
  int fails = 0;
  logic [31:0] hi_m, lo_m;

  mdu_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .A          (A),
    .B          (B),
    .busy       (busy),
    .start_busy (start_busy),
    .hi         (hi),
    .lo         (lo),
    .out        (out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int lat(input logic [3:0] o);
    if (o == 4'd1 || o == 4'd2) return 5;
    if (o == 4'd3 || o == 4'd4) return 10;
    return 0;
  endfunction

  // Reference: plain 64-bit / native signed arithmetic
  task automatic model(input logic [3:0] o,
                       input logic [31:0] a,
                       input logic [31:0] b);
    int ia = a;
    int ib = b;
    longint p;
    longint unsigned u;
    case (o)
      4'd1: begin
        p = longint'(ia) * longint'(ib);
        hi_m = p[63:32];
        lo_m = p[31:0];
      end
      4'd2: begin
        u = longint'({32'd0, a}) * longint'({32'd0, b});
        hi_m = u[63:32];
        lo_m = u[31:0];
      end
      4'd3: if (b != 0) begin
        if (a == 32'h8000_0000 && ib == -1) begin
          lo_m = 32'h8000_0000;
          hi_m = 32'd0;
        end else begin
          lo_m = ia / ib;
          hi_m = ia % ib;
        end
      end
      4'd4: if (b != 0) begin
        lo_m = a / b;
        hi_m = a % b;
      end
      4'd7: hi_m = a;
      4'd8: lo_m = a;
      default: ;
    endcase
  endtask

  task automatic issue(input logic [3:0] o,
                       input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    op = o;
    A = a;
    B = b;
    #1;
    chk("start_busy", {31'd0, start_busy},
        {31'd0, lat(o) != 0});
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 4'd0;
  endtask

  // Counts busy cycles while scrambling operands
  task automatic wait_done(input int n0, input int exp_n,
                           input string tag);
    int n = n0;
    while (busy === 1'b1 && n < 200) begin
      @(negedge clk);
      A = $urandom;
      B = $urandom;
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, n, exp_n);
  endtask

  task automatic chk_out();
    @(negedge clk);
    op = 4'd5;
    #1 chk("out_mfhi", out, hi_m);
    op = 4'd6;
    #1 chk("out_mflo", out, lo_m);
    op = 4'd7;
    #1 chk("out_other", out, 32'd0);
    op = 4'd0;
  endtask

  task automatic run(input logic [3:0] o,
                     input logic [31:0] a,
                     input logic [31:0] b);
    issue(o, a, b);
    if (lat(o) != 0) begin
      chk("busy_rise", {31'd0, busy}, 32'd1);
      chk("hi_hold", hi, hi_m);
      chk("lo_hold", lo, lo_m);
    end
    model(o, a, b);
    wait_done(0, lat(o), "busy_cycles");
    chk("hi", hi, hi_m);
    chk("lo", lo, lo_m);
    chk("busy_low", {31'd0, busy}, 32'd0);
    chk_out();
  endtask

  initial begin
    logic [3:0]  ro;
    logic [31:0] ra, rb;
    int          sel;

    reset = 1'b1;
    start = 1'b0;
    op = 4'd0;
    A = 32'd0;
    B = 32'd0;
    hi_m = 32'd0;
    lo_m = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run(4'd1, 32'hFFFF_FFFE, 32'd3);
    chk("mult_hi_const", hi, 32'hFFFF_FFFF);
    chk("mult_lo_const", lo, 32'hFFFF_FFFA);
    run(4'd2, 32'hFFFF_FFFE, 32'd3);
    chk("multu_hi_const", hi, 32'h0000_0002);
    chk("multu_lo_const", lo, 32'hFFFF_FFFA);
    run(4'd3, 32'hFFFF_FFF9, 32'd2);
    chk("div_lo_const", lo, 32'hFFFF_FFFD);
    chk("div_hi_const", hi, 32'hFFFF_FFFF);
    run(4'd4, 32'd7, 32'd2);
    chk("divu_lo_const", lo, 32'd3);
    chk("divu_hi_const", hi, 32'd1);
    run(4'd7, 32'h1234_5678, 32'd0);
    chk("mthi_const", hi, 32'h1234_5678);
    run(4'd8, 32'hCAFE_F00D, 32'd0);
    run(4'd3, 32'd99, 32'd0);
    chk("divz_hi", hi, 32'h1234_5678);
    chk("divz_lo", lo, 32'hCAFE_F00D);
    run(4'd4, 32'd99, 32'd0);
    run(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'd0);
    run(4'd11, 32'h5555_5555, 32'd1);

    // Start during busy must be ignored
    issue(4'd1, 32'd1000, 32'hFFFF_FFF0);
    model(4'd1, 32'd1000, 32'hFFFF_FFF0);
    @(negedge clk);
    start = 1'b1;
    op = 4'd3;
    A = 32'd100;
    B = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 4'd0;
    wait_done(1, 5, "ign_cycles");
    chk("ign_hi", hi, hi_m);
    chk("ign_lo", lo, lo_m);

    // Reset in busy cycle 4 of a divide
    issue(4'd3, 32'd50, 32'd7);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    hi_m = 32'd0;
    lo_m = 32'd0;
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_hi", hi, 32'd0);
    chk("mrst_lo", lo, 32'd0);
    repeat (15) @(posedge clk);
    #1;
    chk("late_hi", hi, 32'd0);
    chk("late_lo", lo, 32'd0);
    chk("late_busy", {31'd0, busy}, 32'd0);

    // Back-to-back MULT then MULTU
    issue(4'd1, 32'h0001_0003, 32'h0002_0005);
    model(4'd1, 32'h0001_0003, 32'h0002_0005);
    wait_done(0, 5, "b2b_first");
    issue(4'd2, 32'hF000_0001, 32'h0000_0010);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    chk("b2b_hold_hi", hi, hi_m);
    chk("b2b_hold_lo", lo, lo_m);
    model(4'd2, 32'hF000_0001, 32'h0000_0010);
    wait_done(0, 5, "b2b_second");
    chk("b2b_hi", hi, hi_m);
    chk("b2b_lo", lo, lo_m);

    for (int i = 0; i < 40; i++) begin
      ro = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) rb = 32'd0;
      if (sel == 1) rb = 32'hFFFF_FFFF;
      if (sel == 2) ra = 32'h8000_0000;
      if (sel == 3) rb = 32'($urandom_range(1, 9));
      run(ro, ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multi-cycle multiply/divide unit in the E stage.
- It produces the MDU value (mfhi/mflo result) that is carried E->M->W through the pipeline registers and written back in W.
- It owns the HI/LO registers and drives a start/busy handshake that the hazard unit uses to stall D-stage MDU instructions.
- It is the producing end of the mdu path that the M/W register consumes.

Parameters:
- MUL_CYCLES, 5, busy duration for mult/multu (>=1)
- DIV_CYCLES, 10, busy duration for div/divu (>=1)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high; clears all state
- start  input  1  E-stage instruction is an MDU op, valid this cycle
- op  input  4  1=MULT 2=MULTU 3=DIV 4=DIVU 5=MFHI 6=MFLO 7=MTHI 8=MTLO; others = no-op
- A  input  32  rs operand (forwarded)
- B  input  32  rt operand (forwarded)
- busy  output  1  multi-cycle operation in progress
- start_busy  output  1  combinational: start & op in 1..4 (for stall logic)
- hi  output  32  HI register
- lo  output  32  LO register
- out  output  32  combinational: hi if op==MFHI, lo if op==MFLO, else 0

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset: on the posedge with reset=1, hi=0, lo=0, busy=0, cycle counter=0, pending results discarded. Reset takes priority over start and over an in-flight operation.
- States: IDLE (busy=0) and RUN (busy=1). The counter counts down; latched results are held in internal regs hi_n/lo_n.
- IDLE, start=1 with op in MULT..DIVU:
  - latch results this edge: MULT {hi_n,lo_n}=signed A*B (64-bit); MULTU unsigned product; DIV lo_n=signed A/B and hi_n=signed A%B (truncate toward zero, remainder takes the dividend's sign); DIVU unsigned quotient/remainder;
  - load counter with MUL_CYCLES or DIV_CYCLES;
  - go to RUN; busy=1 from the next cycle.
- RUN: counter decrements each cycle. When the counter reaches 1, on that edge hi<=hi_n, lo<=lo_n, busy<=0, go to IDLE.
- Latency: busy is high for exactly MUL_CYCLES/DIV_CYCLES cycles after the start edge. New hi/lo are visible in the cycle busy first reads 0.
- Division by zero (B==0, DIV or DIVU): runs DIV_CYCLES as normal; hi/lo are left unchanged at completion.
- MTHI/MTLO in IDLE with start=1: hi (resp. lo) <= A on that edge, no busy.
- MFHI/MFLO: purely combinational read of current hi/lo; no state change.
- start while busy=1, any op: ignored (hazard unit guarantees a stall). An in-flight operation is not disturbed; out still reflects current hi/lo.
- Completion edge with start=1 at the same time: impossible in legal flow because start is stalled while busy=1. If it occurs anyway, completion wins and start is ignored.
- Signed INT_MIN/-1: lo=0x80000000, hi=0.
- Operands A and B are sampled only at the start edge; later changes have no effect.
- Unknown op with start=1: no-op.

Test Plan:
- MULT A=0xFFFFFFFE(-2) B=3: busy high 5 cycles -> hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV A=-7 (0xFFFFFFF9) B=2: busy 10 cycles -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU A=7 B=2 -> lo=3, hi=1.
- MTHI A=0x12345678 then MFLO/MFHI: hi updates next edge with busy=0; out=0x12345678 when op=MFHI; DIV with B=0 -> after 10 busy cycles hi/lo unchanged.
- Start MULT, then assert start with op=DIV A=100 B=5 during busy -> ignored; final hi/lo equal the MULT result, busy falls after cycle 5.
- Start DIV, assert reset in busy cycle 4 -> next edge busy=0, hi=0, lo=0; no late update afterwards.
- Back-to-back: MULT completes and busy drops; MULTU issued the next cycle -> busy rises again for 5 cycles, and intermediate hi/lo hold the first result.
